// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds the FSM state and owner enums, the bus request bundle and default sizes.
package mem_port_arbiter_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int ADDR_WIDTH       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_RSP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } arb_owner_e;

  // Request fields as they travel from a requester onto the memory bus.
  typedef struct packed {
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive MEM wins while IF waits.
// Clear has priority over increment; at_limit forces the next grant to IF.
module arb_starve_ctr #(
  parameter  int LIMIT = 4,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [W-1:0] cnt_reg;

  assign at_limit = (cnt_reg == W'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && !at_limit) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between IF fetches and MEM loads/stores.
// Optional ARB_PERF_CNT_EN adds wait/conflict/drop performance counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_WIDTH,
  parameter int DATA_W       = DATA_WIDTH,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_be_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic                mem_gnt_o,
  output logic                mem_rvalid_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]         perf_if_wait_o,
  output logic [31:0]         perf_conflict_o,
  output logic [31:0]         perf_drop_o,
`endif
  output logic                busy_o
);

  arb_state_e  state_reg, state_next;
  arb_owner_e  owner_reg, owner_next, winner;
  logic        drop_reg, drop_next;
  logic        owner_we_reg, owner_we_next;
  logic        if_rvalid_reg, mem_rvalid_reg;
  logic [DATA_W-1:0] if_rdata_reg, mem_rdata_reg;
  mem_req_t    win_req;
  logic        in_idle, if_req_eff, at_limit, accept;
  logic        rsp_valid, rsp_to_if, rsp_to_mem, if_drop_evt;

  assign in_idle    = (state_reg == ARB_IDLE);
  assign if_req_eff = if_req_i && !if_flush_i;

  // Gating with rst keeps every bus-facing output low while reset is held.
  always_comb begin
    winner  = OWN_NONE;
    win_req = '0;
    if (rst && in_idle) begin
      if (mem_req_i && !(if_req_eff && at_limit)) begin
        winner  = OWN_MEM;
        win_req = '{we: mem_we_i, be: mem_be_i, addr: mem_addr_i, wdata: mem_wdata_i};
      end else if (if_req_eff) begin
        winner  = OWN_IF;
        win_req = '{we: 1'b0, be: '1, addr: if_addr_i, wdata: '0};
      end
    end
  end

  assign bus_req_o   = (winner != OWN_NONE);
  assign bus_we_o    = win_req.we;
  assign bus_be_o    = win_req.be;
  assign bus_addr_o  = win_req.addr;
  assign bus_wdata_o = win_req.wdata;
  assign if_gnt_o    = bus_gnt_i && (winner == OWN_IF);
  assign mem_gnt_o   = bus_gnt_i && (winner == OWN_MEM);
  assign accept      = bus_req_o && bus_gnt_i;
  assign busy_o      = !in_idle;

  assign rsp_valid   = !in_idle && bus_rvalid_i;
  assign rsp_to_mem  = rsp_valid && (owner_reg == OWN_MEM);
  assign rsp_to_if   = rsp_valid && (owner_reg == OWN_IF) && !(drop_reg || if_flush_i);
  assign if_drop_evt = rsp_valid && (owner_reg == OWN_IF) && (drop_reg || if_flush_i);

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept && (winner == OWN_MEM) && if_req_i),
    .clr      ((in_idle && !if_req_i) || (accept && (winner == OWN_IF))),
    .at_limit (at_limit)
  );

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    drop_next     = drop_reg;
    owner_we_next = owner_we_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (accept) begin
          state_next    = ARB_WAIT_RSP;
          owner_next    = winner;
          owner_we_next = win_req.we;
          drop_next     = 1'b0;
        end
      end
      ARB_WAIT_RSP: begin
        if (bus_rvalid_i) begin
          state_next = ARB_IDLE;
          owner_next = OWN_NONE;
          drop_next  = 1'b0;
        end else if (owner_reg == OWN_IF && if_flush_i) begin
          drop_next = 1'b1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        owner_next = OWN_NONE;
        drop_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_NONE;
      drop_reg       <= 1'b0;
      owner_we_reg   <= 1'b0;
      if_rvalid_reg  <= 1'b0;
      mem_rvalid_reg <= 1'b0;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      drop_reg       <= drop_next;
      owner_we_reg   <= owner_we_next;
      if_rvalid_reg  <= rsp_to_if;
      mem_rvalid_reg <= rsp_to_mem;
      if (rsp_to_if) if_rdata_reg <= bus_rdata_i;
      if (rsp_to_mem) mem_rdata_reg <= owner_we_reg ? '0 : bus_rdata_i;
    end
  end

  assign if_rvalid_o  = if_rvalid_reg;
  assign if_rdata_o   = if_rdata_reg;
  assign mem_rvalid_o = mem_rvalid_reg;
  assign mem_rdata_o  = mem_rdata_reg;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait_reg, perf_conflict_reg, perf_drop_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_wait_reg  <= '0;
      perf_conflict_reg <= '0;
      perf_drop_reg     <= '0;
    end else begin
      if (if_req_i && !if_gnt_o) perf_if_wait_reg <= perf_if_wait_reg + 32'd1;
      if (in_idle && if_req_i && mem_req_i) perf_conflict_reg <= perf_conflict_reg + 32'd1;
      if (if_drop_evt) perf_drop_reg <= perf_drop_reg + 32'd1;
    end
  end

  assign perf_if_wait_o  = perf_if_wait_reg;
  assign perf_conflict_o = perf_conflict_reg;
  assign perf_drop_o     = perf_drop_reg;
`endif

  // A response with no transaction outstanding means the memory broke protocol.
  assert property (@(posedge clk) disable iff (!rst) !(in_idle && bus_rvalid_i));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected read data is queued when a grant is
// expected and popped when the matching rvalid pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, mem_req, mem_we, bus_gnt, bus_rvalid;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_be;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
  logic        bus_req, bus_we, busy;
  logic [3:0]  bus_be;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait, perf_conflict, perf_drop;
`endif

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  int checks = 0;
  int errors = 0;
  int if_rv_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (if_rvalid) if_rv_cnt++;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_flush_i   (if_flush),
    .if_gnt_o     (if_gnt),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_be_i     (mem_be),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_gnt_o    (mem_gnt),
    .mem_rvalid_o (mem_rvalid),
    .mem_rdata_o  (mem_rdata),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_be_o     (bus_be),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata),
`ifdef ARB_PERF_CNT_EN
    .perf_if_wait_o  (perf_if_wait),
    .perf_conflict_o (perf_conflict),
    .perf_drop_o     (perf_drop),
`endif
    .busy_o       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_be = 0; mem_addr = 0; mem_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    if_q.delete();
    mem_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    mem_req = 1; if_req = 1; bus_gnt = 1;
    #3;
    checks++;
    if ({bus_req, if_gnt, mem_gnt, if_rvalid, mem_rvalid, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000",
        {bus_req, if_gnt, mem_gnt, if_rvalid, mem_rvalid, busy});
    end
    checks++;
    if ({if_rdata, mem_rdata, bus_addr} !== 96'b0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0", if_rdata, mem_rdata, bus_addr);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_if_only();
    logic [31:0] exp;
    do_reset();
    if_req = 1; if_addr = 32'h10; bus_gnt = 1;
    #1;
    checks++;
    if ({if_gnt, mem_gnt, bus_req, bus_we, bus_be, bus_addr} !== {4'b1010, 4'hF, 32'h10}) begin
      errors++; $display("FAIL if_grant: got gnt=%b req=%b we=%b be=%h addr=%h want gnt=1 req=1 we=0 be=f addr=10",
        if_gnt, bus_req, bus_we, bus_be, bus_addr);
    end
    if_q.push_back(32'h00500093);
    tick();
    if_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h00500093;
    #1;
    checks++;
    if ({busy, if_gnt, bus_req, if_rvalid} !== 4'b1000) begin
      errors++; $display("FAIL if_wait: got busy=%b gnt=%b req=%b rv=%b want 1000", busy, if_gnt, bus_req, if_rvalid);
    end
    tick();
    bus_rvalid = 0;
    checks++;
    if (if_rvalid !== 1'b1 || if_q.size() == 0) begin
      errors++; $display("FAIL if_rvalid: got %b want 1 at cycle 2", if_rvalid);
    end else begin
      exp = if_q.pop_front();
      if (if_rdata !== exp) begin
        errors++; $display("FAIL if_rdata: got %h want %h", if_rdata, exp);
      end
      $display("IF  read addr=%h data=%h", 32'h10, if_rdata);
    end
    tick();
    checks++;
    if (if_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL if_pulse: got rv=%b busy=%b want 0 0", if_rvalid, busy);
    end
  endtask

  task automatic test_mem_priority();
    logic [31:0] exp;
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_req = 1; mem_addr = 32'h100; bus_gnt = 1;
    #1;
    checks++;
    if ({mem_gnt, if_gnt} !== 2'b10 || bus_addr !== 32'h100) begin
      errors++; $display("FAIL prio_grant: got mem=%b if=%b addr=%h want 1 0 100", mem_gnt, if_gnt, bus_addr);
    end
    mem_q.push_back(32'hDEADBEEF);
    tick();
    mem_req = 0; bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({if_gnt, bus_req} !== 2'b00) begin
      errors++; $display("FAIL prio_wait: got if_gnt=%b req=%b want 0 0", if_gnt, bus_req);
    end
    tick();
    bus_rvalid = 0;
    #1;
    checks++;
    if (mem_rvalid !== 1'b1 || mem_q.size() == 0) begin
      errors++; $display("FAIL prio_mem_rvalid: got %b want 1", mem_rvalid);
    end else begin
      exp = mem_q.pop_front();
      if (mem_rdata !== exp) begin
        errors++; $display("FAIL prio_mem_rdata: got %h want %h", mem_rdata, exp);
      end
      $display("MEM load addr=%h data=%h", 32'h100, mem_rdata);
    end
    checks++;
    if (if_gnt !== 1'b1 || bus_addr !== 32'h40) begin
      errors++; $display("FAIL prio_if_after: got gnt=%b addr=%h want 1 40", if_gnt, bus_addr);
    end
    if_q.push_back(32'hCAFE0001);
    tick();
    if_req = 0; bus_rvalid = 1; bus_rdata = 32'hCAFE0001;
    tick();
    bus_rvalid = 0;
    checks++;
    if (if_rvalid !== 1'b1 || if_q.size() == 0) begin
      errors++; $display("FAIL prio_if_rvalid: got %b want 1", if_rvalid);
    end else begin
      exp = if_q.pop_front();
      if (if_rdata !== exp) begin
        errors++; $display("FAIL prio_if_rdata: got %h want %h", if_rdata, exp);
      end
      $display("IF  read addr=%h data=%h", 32'h40, if_rdata);
    end
  endtask

  task automatic test_starvation();
    int mcnt = 0;
    int wait_exp = 0;
    int conf_exp = 0;
    logic exp_if;
    logic [31:0] data, exp;
    do_reset();
    if_addr = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      if_req = 1; mem_req = 1; mem_we = 0; mem_addr = 32'h300 + 32'(4 * i); bus_gnt = 1;
      #1;
      exp_if = (mcnt == 4);
      checks++;
      if ({if_gnt, mem_gnt} !== {exp_if, !exp_if}) begin
        errors++; $display("FAIL starve_grant%0d: got if=%b mem=%b want if=%b mem=%b",
          i, if_gnt, mem_gnt, exp_if, !exp_if);
      end
      data = 32'hA0000000 + 32'(i);
      if (exp_if) if_q.push_back(data); else mem_q.push_back(data);
      mcnt = exp_if ? 0 : ((mcnt < 4) ? mcnt + 1 : mcnt);
      conf_exp++;
      if (!exp_if) wait_exp++;
      tick();
      if (exp_if) if_addr = if_addr + 32'd4;
      bus_rvalid = 1; bus_rdata = data;
      wait_exp++;
      tick();
      bus_rvalid = 0;
      checks++;
      if (exp_if) begin
        if (if_rvalid !== 1'b1 || mem_rvalid !== 1'b0 || if_q.size() == 0) begin
          errors++; $display("FAIL starve_rsp%0d: got if_rv=%b mem_rv=%b want 1 0", i, if_rvalid, mem_rvalid);
        end else begin
          exp = if_q.pop_front();
          if (if_rdata !== exp) begin
            errors++; $display("FAIL starve_if_data%0d: got %h want %h", i, if_rdata, exp);
          end
          $display("IF  read #%0d data=%h", i, if_rdata);
        end
      end else begin
        if (mem_rvalid !== 1'b1 || if_rvalid !== 1'b0 || mem_q.size() == 0) begin
          errors++; $display("FAIL starve_rsp%0d: got mem_rv=%b if_rv=%b want 1 0", i, mem_rvalid, if_rvalid);
        end else begin
          exp = mem_q.pop_front();
          if (mem_rdata !== exp) begin
            errors++; $display("FAIL starve_mem_data%0d: got %h want %h", i, mem_rdata, exp);
          end
          $display("MEM load #%0d data=%h", i, mem_rdata);
        end
      end
    end
    idle_inputs();
    tick();
`ifdef ARB_PERF_CNT_EN
    checks++;
    if (perf_if_wait !== 32'(wait_exp) || perf_conflict !== 32'(conf_exp)) begin
      errors++; $display("FAIL perf_counts: got wait=%0d conflict=%0d want %0d %0d",
        perf_if_wait, perf_conflict, wait_exp, conf_exp);
    end
`endif
  endtask

  task automatic test_flush();
    int rv0;
    logic [31:0] exp;
    do_reset();
    if_req = 1; if_addr = 32'h30; bus_gnt = 1;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL flush_grant: got %b want 1", if_gnt);
    end
    tick();
    if_req = 0; bus_gnt = 0; if_flush = 1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_busy: got %b want 1", busy);
    end
    rv0 = if_rv_cnt;
    tick();
    if_flush = 0; bus_rvalid = 1; bus_rdata = 32'hBAD0BAD0;
    tick();
    bus_rvalid = 0;
    checks++;
    if (if_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got rv=%b busy=%b want 0 0", if_rvalid, busy);
    end
    tick();
    checks++;
    if (if_rv_cnt !== rv0) begin
      errors++; $display("FAIL flush_no_pulse: got %0d pulses want 0", if_rv_cnt - rv0);
    end
    $display("IF  read addr=%h dropped by flush", 32'h30);
    if_req = 1; if_addr = 32'h20; if_flush = 1; bus_gnt = 1;
    #1;
    checks++;
    if ({if_gnt, bus_req} !== 2'b00) begin
      errors++; $display("FAIL flush_mask: got gnt=%b req=%b want 0 0", if_gnt, bus_req);
    end
    tick();
    if_flush = 0;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || bus_addr !== 32'h20) begin
      errors++; $display("FAIL flush_next_grant: got gnt=%b addr=%h want 1 20", if_gnt, bus_addr);
    end
    if_q.push_back(32'h00200013);
    tick();
    if_req = 0; bus_rvalid = 1; bus_rdata = 32'h00200013;
    tick();
    bus_rvalid = 0;
    checks++;
    if (if_rvalid !== 1'b1 || if_q.size() == 0) begin
      errors++; $display("FAIL flush_next_rvalid: got %b want 1", if_rvalid);
    end else begin
      exp = if_q.pop_front();
      if (if_rdata !== exp) begin
        errors++; $display("FAIL flush_next_rdata: got %h want %h", if_rdata, exp);
      end
      $display("IF  read addr=%h data=%h", 32'h20, if_rdata);
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if (perf_drop !== 32'd1) begin
      errors++; $display("FAIL perf_drop: got %0d want 1", perf_drop);
    end
`endif
  endtask

  task automatic test_store();
    logic [31:0] exp;
    do_reset();
    mem_req = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'h1234; bus_gnt = 1;
    #1;
    checks++;
    if ({mem_gnt, bus_we, bus_be, bus_addr, bus_wdata} !== {2'b11, 4'b0011, 32'h200, 32'h1234}) begin
      errors++; $display("FAIL store_bus: got gnt=%b we=%b be=%b addr=%h wdata=%h want 1 1 0011 200 1234",
        mem_gnt, bus_we, bus_be, bus_addr, bus_wdata);
    end
    mem_q.push_back(32'h0);
    tick();
    mem_req = 0; mem_we = 0; bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_rvalid = 0;
    checks++;
    if (mem_rvalid !== 1'b1 || mem_q.size() == 0) begin
      errors++; $display("FAIL store_ack: got %b want 1", mem_rvalid);
    end else begin
      exp = mem_q.pop_front();
      if (mem_rdata !== exp) begin
        errors++; $display("FAIL store_rdata: got %h want %h", mem_rdata, exp);
      end
      $display("MEM store addr=%h ack data=%h", 32'h200, mem_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int rv0;
    logic [31:0] exp;
    do_reset();
    if_req = 1; if_addr = 32'h50; bus_gnt = 1;
    tick();
    if_req = 0; mem_req = 1; mem_addr = 32'h400; bus_gnt = 0;
    rv0 = if_rv_cnt;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got %b want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, bus_req, mem_gnt, if_gnt, if_rvalid, mem_rvalid} !== 6'b0) begin
      errors++; $display("FAIL rstmid_outputs: got %b want 000000",
        {busy, bus_req, mem_gnt, if_gnt, if_rvalid, mem_rvalid});
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus_req, mem_gnt} !== 2'b10 || bus_addr !== 32'h400) begin
        errors++; $display("FAIL rstmid_stall%0d: got req=%b gnt=%b addr=%h want 1 0 400",
          i, bus_req, mem_gnt, bus_addr);
      end
      tick();
    end
    bus_gnt = 1;
    #1;
    checks++;
    if (mem_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_grant: got %b want 1", mem_gnt);
    end
    mem_q.push_back(32'h600D600D);
    tick();
    mem_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h600D600D;
    tick();
    bus_rvalid = 0;
    checks++;
    if (mem_rvalid !== 1'b1 || mem_q.size() == 0) begin
      errors++; $display("FAIL rstmid_rvalid: got %b want 1", mem_rvalid);
    end else begin
      exp = mem_q.pop_front();
      if (mem_rdata !== exp) begin
        errors++; $display("FAIL rstmid_rdata: got %h want %h", mem_rdata, exp);
      end
      $display("MEM load addr=%h data=%h after reset", 32'h400, mem_rdata);
    end
    tick();
    checks++;
    if (if_rv_cnt !== rv0) begin
      errors++; $display("FAIL rstmid_lost_if: got %0d IF pulses want 0", if_rv_cnt - rv0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_if_only();
    test_mem_priority();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
